// File: rtl/alu_mp_seq.sv
// alu_mp_seq: little-endian multi-byte ADD/SUB/LSL sequencer over the shared alu.
// Optional LSL-by-1 (op 10) is compiled in when ALU_MP_SEQ_LSL_EN is defined.
module alu_mp_seq #(
    parameter int         NBYTES  = 4,
    parameter int         LEN_W   = 3,
    parameter logic [7:0] ALU_ADD = 8'h01,
    parameter logic [7:0] ALU_SUB = 8'h02
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       a_base_i,
    input  logic [7:0]       b_base_i,
    input  logic [7:0]       d_base_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic [7:0]       mem_addr_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic [7:0]       mem_wdata_o,
    input  logic [7:0]       mem_rdata_i,
    output logic [8:0]       alu_op_o,
    output logic [7:0]       alu_rs_o,
    output logic [7:0]       alu_rt_o,
    input  logic [7:0]       alu_result_i,
    input  logic             alu_carry_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        OP1,
        OP2,
        WR,
        DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       a_base_q;
    logic [7:0]       b_base_q;
    logic [7:0]       d_base_q;
    logic             sub_q;
`ifdef ALU_MP_SEQ_LSL_EN
    logic             lsl_q;
`endif
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] i_q;
    logic [LEN_W-1:0] i_nxt;
    logic [LEN_W-1:0] len_clamp;
    logic [7:0]       idx8;
    logic [7:0]       a_q;
    logic [7:0]       r1_q;
    logic [7:0]       r2_q;
    logic             c1_q;
    logic             c2_q;
    logic             cin_q;
    logic             zacc_q;
    logic             op_ok;

    // Request decode: clamp length, accept only implemented ops.
    always_comb begin
        len_clamp = len_i;
        if (len_i > LEN_W'(NBYTES))
            len_clamp = LEN_W'(NBYTES);
        op_ok = (op_i == 2'b00) || (op_i == 2'b01);
`ifdef ALU_MP_SEQ_LSL_EN
        op_ok = op_ok || (op_i == 2'b10);
`endif
        i_nxt = i_q + LEN_W'(1);
        idx8  = 8'(i_q);
    end

    // ALU drive: byte op in OP1, carry/borrow fold-in in OP2, else quiet.
    always_comb begin
        alu_op_o = '0;
        alu_rs_o = '0;
        alu_rt_o = '0;
        if (state_q == OP1 || state_q == OP2)
            alu_op_o = sub_q ? {ALU_SUB, 1'b0} : {ALU_ADD, 1'b0};
        if (state_q == OP1) begin
            alu_rs_o = a_q;
            alu_rt_o = mem_rdata_i;
`ifdef ALU_MP_SEQ_LSL_EN
            if (lsl_q)
                alu_rs_o = mem_rdata_i;
`endif
        end else if (state_q == OP2) begin
            alu_rs_o = r1_q;
            alu_rt_o = {7'b0, cin_q};
        end
    end

    // Sequencer FSM with registered memory and status outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            a_base_q    <= '0;
            b_base_q    <= '0;
            d_base_q    <= '0;
            sub_q       <= 1'b0;
`ifdef ALU_MP_SEQ_LSL_EN
            lsl_q       <= 1'b0;
`endif
            len_q       <= '0;
            i_q         <= '0;
            a_q         <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            c1_q        <= 1'b0;
            c2_q        <= 1'b0;
            cin_q       <= 1'b0;
            zacc_q      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            carry_o     <= 1'b0;
            zero_o      <= 1'b0;
            mem_addr_o  <= '0;
            mem_rd_o    <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_wdata_o <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (op_ok && len_clamp != '0) begin
                            a_base_q   <= a_base_i;
                            b_base_q   <= b_base_i;
                            d_base_q   <= d_base_i;
                            sub_q      <= (op_i == 2'b01);
`ifdef ALU_MP_SEQ_LSL_EN
                            lsl_q      <= (op_i == 2'b10);
`endif
                            len_q      <= len_clamp;
                            i_q        <= '0;
                            cin_q      <= 1'b0;
                            zacc_q     <= 1'b1;
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= a_base_i;
                            state_q    <= RD_A;
                        end else begin
                            done_o  <= 1'b1;
                            carry_o <= 1'b0;
                            zero_o  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RD_A: begin
`ifdef ALU_MP_SEQ_LSL_EN
                    if (lsl_q) begin
                        mem_rd_o   <= 1'b0;
                        mem_addr_o <= '0;
                        state_q    <= OP1;
                    end else
`endif
                    begin
                        mem_addr_o <= b_base_q + idx8;
                        state_q    <= RD_B;
                    end
                end
                RD_B: begin
                    a_q        <= mem_rdata_i;
                    mem_rd_o   <= 1'b0;
                    mem_addr_o <= '0;
                    state_q    <= OP1;
                end
                OP1: begin
                    r1_q    <= alu_result_i;
                    c1_q    <= alu_carry_i;
                    state_q <= OP2;
                end
                OP2: begin
                    r2_q        <= alu_result_i;
                    c2_q        <= alu_carry_i;
                    mem_wr_o    <= 1'b1;
                    mem_addr_o  <= d_base_q + idx8;
                    mem_wdata_o <= alu_result_i;
                    state_q     <= WR;
                end
                WR: begin
                    mem_wr_o    <= 1'b0;
                    mem_wdata_o <= '0;
                    cin_q       <= c1_q | c2_q;
                    zacc_q      <= zacc_q & (r2_q == 8'd0);
                    i_q         <= i_nxt;
                    if (i_nxt == len_q) begin
                        done_o     <= 1'b1;
                        carry_o    <= c1_q | c2_q;
                        zero_o     <= zacc_q & (r2_q == 8'd0);
                        mem_addr_o <= '0;
                        state_q    <= DONE;
                    end else begin
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= a_base_q + 8'(i_nxt);
                        state_q    <= RD_A;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_seq.sv
// tb_alu_mp_seq: directed scoreboard bench for alu_mp_seq.
// Memory and alu are modelled here; expectations use whole-word arithmetic.
`timescale 1ns/1ns
module tb_alu_mp_seq;

    localparam logic [7:0] ADD_OP = 8'h01;
    localparam logic [7:0] SUB_OP = 8'h02;
`ifdef ALU_MP_SEQ_LSL_EN
    localparam bit LSL_ON = 1'b1;
`else
    localparam bit LSL_ON = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic        carry;
        logic        zero;
        logic [7:0]  d;
        int          len;
        logic [31:0] res;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] op_i = '0;
    logic [2:0] len_i = '0;
    logic [7:0] a_base_i = '0;
    logic [7:0] b_base_i = '0;
    logic [7:0] d_base_i = '0;
    logic       busy_o, done_o, carry_o, zero_o;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       mem_rd, mem_wr;
    logic [8:0] alu_op;
    logic [7:0] alu_rs, alu_rt, alu_result;
    logic       alu_carry;
    logic [8:0] alu_sum;

    logic [7:0] mem [256];
    logic       bd_we = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    sb_t        sb [$];
    logic [7:0] rd_q [$];
    logic [7:0] wr_q [$];
    time        t0 = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       last_carry = 1'b0;
    logic       last_zero = 1'b0;
    sb_t        me;
    int         mk;

    always #5 clk = ~clk;

    alu_mp_seq #(
        .NBYTES (4),
        .LEN_W  (3),
        .ALU_ADD(ADD_OP),
        .ALU_SUB(SUB_OP)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .len_i       (len_i),
        .a_base_i    (a_base_i),
        .b_base_i    (b_base_i),
        .d_base_i    (d_base_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .carry_o     (carry_o),
        .zero_o      (zero_o),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .alu_op_o    (alu_op),
        .alu_rs_o    (alu_rs),
        .alu_rt_o    (alu_rt),
        .alu_result_i(alu_result),
        .alu_carry_i (alu_carry)
    );

    // Combinational alu: 9-bit sum/difference, bit 8 is carry/borrow.
    always_comb begin
        alu_sum = '0;
        if (alu_op[8:1] == ADD_OP)
            alu_sum = {1'b0, alu_rs} + {1'b0, alu_rt};
        else if (alu_op[8:1] == SUB_OP)
            alu_sum = {1'b0, alu_rs} - {1'b0, alu_rt};
    end
    assign alu_result = alu_sum[7:0];
    assign alu_carry  = alu_sum[8];

    // Synchronous-read data memory with a bench backdoor.
    always @(posedge clk) begin
        if (clr)
            for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
        if (bd_we)
            mem[bd_addr] <= bd_data;
        if (mem_wr)
            mem[mem_addr] <= mem_wdata;
        if (mem_rd)
            mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every access and every done pulse must match the scoreboard.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (mem_rd) begin
                if (rd_q.size() == 0) check("rd_extra", mem_rd, 1'b0);
                else check("rd_addr", mem_addr, rd_q.pop_front());
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) check("wr_extra", mem_wr, 1'b0);
                else check("wr_addr", mem_addr, wr_q.pop_front());
            end
            if (done_o) begin
                if (sb.size() == 0) check("done_extra", done_o, 1'b0);
                else begin
                    me = sb.pop_front();
                    mk = int'(($time - t0 - 5) / 10) + 1;
                    check("done_cycle", mk, me.cyc);
                    check("carry", carry_o, me.carry);
                    check("zero", zero_o, me.zero);
                    check("busy_in_done", busy_o, 1'b1);
                    last_carry = me.carry;
                    last_zero  = me.zero;
                    for (int k = 0; k < me.len; k++)
                        check("dbyte", mem[8'(me.d + k)], me.res[8*k +: 8]);
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        bd_addr = a;
        bd_data = v;
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic load(input logic [7:0] base, input logic [31:0] v,
                        input int n);
        for (int k = 0; k < n; k++) poke(8'(base + k), v[8*k +: 8]);
    endtask

    task automatic launch(input logic [1:0] op, input int len,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d);
        sb_t         e;
        int          n;
        bit          ok;
        logic [39:0] av, bv, rv;
        n  = (len > 4) ? 4 : len;
        ok = (op == 2'b00) || (op == 2'b01) || (op == 2'b10 && LSL_ON);
        e.d = d; e.len = 0; e.res = '0;
        e.carry = 1'b0; e.zero = 1'b1; e.cyc = 1;
        if (ok && n != 0) begin
            av = '0;
            bv = '0;
            for (int k = 0; k < n; k++) begin
                av[8*k +: 8] = mem[8'(a + k)];
                bv[8*k +: 8] = mem[8'(b + k)];
                rd_q.push_back(8'(a + k));
                if (op != 2'b10) rd_q.push_back(8'(b + k));
                wr_q.push_back(8'(d + k));
            end
            if (op == 2'b00) begin
                rv = av + bv;
                e.carry = rv[8*n];
            end else if (op == 2'b01) begin
                rv = av - bv;
                e.carry = (av < bv);
            end else begin
                rv = av << 1;
                e.carry = rv[8*n];
            end
            e.res = rv[31:0];
            for (int k = n; k < 4; k++) e.res[8*k +: 8] = 8'h00;
            e.zero = (e.res == 32'd0);
            e.len  = n;
            e.cyc  = ((op == 2'b10) ? 4 : 5) * n + 1;
        end
        sb.push_back(e);
        @(negedge clk);
        op_i = op; len_i = 3'(len);
        a_base_i = a; b_base_i = b; d_base_i = d;
        start_i = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy_o && c < 200);
        check({tag, "_idle"}, busy_o, 1'b0);
        check({tag, "_sb_left"}, sb.size(), 0);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_wr_left"}, wr_q.size(), 0);
        check({tag, "_carry_hold"}, carry_o, last_carry);
        check({tag, "_zero_hold"}, zero_o, last_zero);
    endtask

    initial begin
        sb_t        tmp;
        logic [7:0] exp0;
        int         nw;
        logic [1:0] rop;
        int         rlen;

        #1 reset_i = 1'b1;
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_carry", carry_o, 1'b0);
        check("rst_zero", zero_o, 1'b0);
        check("rst_rd", mem_rd, 1'b0);
        check("rst_wr", mem_wr, 1'b0);
        check("rst_alu", {alu_op, alu_rs, alu_rt}, 25'd0);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;

        load(8'h10, 32'h01FF, 2);
        load(8'h20, 32'h0001, 2);
        launch(2'b00, 2, 8'h10, 8'h20, 8'h30);
        wait_idle("add2");

        load(8'h10, 32'hFFFF_FFFF, 4);
        load(8'h20, 32'h0000_0001, 4);
        launch(2'b00, 4, 8'h10, 8'h20, 8'h30);
        wait_idle("add4");

        load(8'h10, 32'h0100, 2);
        load(8'h20, 32'h0001, 2);
        launch(2'b01, 2, 8'h10, 8'h20, 8'h30);
        wait_idle("sub_nb");

        load(8'h10, 32'h0000, 2);
        launch(2'b01, 2, 8'h10, 8'h20, 8'h30);
        wait_idle("sub_b");

        load(8'h10, 32'h8001, 2);
        load(8'h30, 32'hA5A5, 2);
        launch(2'b10, 2, 8'h10, 8'h20, 8'h30);
        wait_idle("lsl");

        launch(2'b00, 0, 8'h10, 8'h20, 8'h30);
        wait_idle("len0");

        launch(2'b11, 2, 8'h10, 8'h20, 8'h30);
        wait_idle("rsvd");

        load(8'hFF, 32'h1234, 2);
        load(8'h20, 32'h00F0, 2);
        launch(2'b00, 2, 8'hFF, 8'h20, 8'h40);
        wait_idle("wrap");

        load(8'h10, 32'h8000_0001, 4);
        load(8'h20, 32'h8000_0002, 4);
        launch(2'b00, 7, 8'h10, 8'h20, 8'h40);
        wait_idle("clamp");

        load(8'h10, 32'h00AB_CDEF, 3);
        load(8'h20, 32'h0012_3456, 3);
        launch(2'b00, 3, 8'h10, 8'h20, 8'h50);
        repeat (3) @(negedge clk);
        op_i = 2'b01; len_i = 3'd1; a_base_i = 8'hAA; d_base_i = 8'h60;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        wait_idle("busy_start");

        for (int t = 0; t < 6; t++) begin
            rop  = 2'($urandom_range(0, 1));
            rlen = $urandom_range(1, 4);
            load(8'h40, $urandom, 4);
            load(8'h50, $urandom, 4);
            launch(rop, rlen, 8'h40, 8'h50, 8'h60);
            wait_idle("rand");
        end

        poke(8'h80, 8'hA5);
        poke(8'h81, 8'h5A);
        load(8'h70, 32'h1122_3344, 4);
        load(8'h78, 32'h0101_0101, 4);
        launch(2'b00, 4, 8'h70, 8'h78, 8'h80);
        tmp  = sb[sb.size()-1];
        exp0 = tmp.res[7:0];
        nw = 0;
        for (int c = 0; c < 100 && nw < 2; c++) begin
            @(negedge clk);
            if (mem_wr) nw++;
        end
        check("rst_wr_seen", nw, 2);
        #2 reset_i = 1'b1;
        #1;
        check("rst_mid_wr", mem_wr, 1'b0);
        check("rst_mid_busy", busy_o, 1'b0);
        sb.delete();
        rd_q.delete();
        wr_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_done", done_o, 1'b0);
        end
        check("rst_kept_b0", mem[8'h80], exp0);
        check("rst_no_b1", mem[8'h81], 8'h5A);
        #2 reset_i = 1'b0;
        load(8'h10, 32'h0003_0000, 3);
        load(8'h20, 32'h0000_0001, 3);
        launch(2'b01, 3, 8'h10, 8'h20, 8'h90);
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
